// File: rtl/scan_chain_controller.sv
// Scan-port driver: loads a parallel word into a serial scan chain MSB-first
// while shifting the previous chain contents out and returning them as a word.
module scan_chain_controller #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CHAIN_LEN-1:0] start_data,
    input  logic                 start_capture,
    output logic                 capture_enable,
    output logic                 scan_enable,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [CHAIN_LEN-1:0] done_data,
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a posedge where valid && ready are both
    // high; valid and its data stay stable until that edge, and ready never
    // depends combinationally on valid.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    logic [CHAIN_LEN-1:0] r_tx;
    logic [CHAIN_LEN-1:0] r_rx;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_start_ready;
    logic                 r_capture_enable;
    logic                 r_scan_enable;
    logic                 r_busy;
    logic                 r_done_valid;

    logic                 w_last_shift;

    assign w_last_shift = (r_cnt == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_tx             <= '0;
            r_rx             <= '0;
            r_cnt            <= '0;
            r_start_ready    <= 1'b1;
            r_capture_enable <= 1'b0;
            r_scan_enable    <= 1'b0;
            r_busy           <= 1'b0;
            r_done_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid && r_start_ready) begin
                        r_tx          <= start_data;
                        r_rx          <= '0;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (start_capture) begin
                            r_state          <= S_CAPTURE;
                            r_capture_enable <= 1'b1;
                        end else begin
                            r_state       <= S_SHIFT;
                            r_scan_enable <= 1'b1;
                        end
                    end
                end

                S_CAPTURE: begin
                    r_capture_enable <= 1'b0;
                    r_scan_enable    <= 1'b1;
                    r_state          <= S_SHIFT;
                end

                S_SHIFT: begin
                    r_tx  <= {r_tx[CHAIN_LEN-2:0], 1'b0};
                    r_rx  <= {r_rx[CHAIN_LEN-2:0], scan_out};
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The counter reaches CHAIN_LEN on this edge.
                    if (w_last_shift) begin
                        r_scan_enable <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done_valid  <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_state          <= S_IDLE;
                    r_start_ready    <= 1'b1;
                    r_capture_enable <= 1'b0;
                    r_scan_enable    <= 1'b0;
                    r_busy           <= 1'b0;
                    r_done_valid     <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready    = r_start_ready;
    assign capture_enable = r_capture_enable;
    assign scan_enable    = r_scan_enable;
    // Gated so the chain sees 0 whenever it is not shifting.
    assign scan_in        = r_scan_enable & r_tx[CHAIN_LEN-1];
    assign busy           = r_busy;
    assign done_valid     = r_done_valid;
    assign done_data      = r_rx;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller: an 8-bit chain for the main
// scenarios plus 2- and 16-bit chains for a small width sweep.
module tb_scan_chain_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic [15:0] exp_q[$];

    // ---------------- 8-bit instance ----------------
    logic       sv_a = 1'b0, cap_a = 1'b0, dr_a = 1'b0;
    logic [7:0] sd_a = 8'h00;
    logic       sr_a, ce_a, se_a, si_a, so_a, busy_a, dv_a;
    logic [7:0] dd_a;
    logic [1:0] st_a;
    logic [7:0] chain_a = 8'h00;
    logic [7:0] din_a   = 8'h00;

    scan_chain_controller #(.CHAIN_LEN(8)) u_a (
        .clk(clk), .rst(rst),
        .start_valid(sv_a), .start_ready(sr_a), .start_data(sd_a), .start_capture(cap_a),
        .capture_enable(ce_a), .scan_enable(se_a), .scan_in(si_a), .scan_out(so_a),
        .busy(busy_a), .done_valid(dv_a), .done_ready(dr_a), .done_data(dd_a),
        .dbg_state(st_a)
    );

    always @(posedge clk) begin
        if (ce_a)      chain_a <= din_a;
        else if (se_a) chain_a <= {chain_a[6:0], si_a};
    end
    assign so_a = chain_a[7];

    // ---------------- 2-bit instance ----------------
    logic       sv_b = 1'b0, dr_b = 1'b0;
    logic [1:0] sd_b = 2'b00;
    logic       sr_b, ce_b, se_b, si_b, so_b, busy_b, dv_b;
    logic [1:0] dd_b;
    logic [1:0] st_b;
    logic [1:0] chain_b = 2'b00;

    scan_chain_controller #(.CHAIN_LEN(2)) u_b (
        .clk(clk), .rst(rst),
        .start_valid(sv_b), .start_ready(sr_b), .start_data(sd_b), .start_capture(1'b0),
        .capture_enable(ce_b), .scan_enable(se_b), .scan_in(si_b), .scan_out(so_b),
        .busy(busy_b), .done_valid(dv_b), .done_ready(dr_b), .done_data(dd_b),
        .dbg_state(st_b)
    );

    always @(posedge clk) begin
        if (se_b) chain_b <= {chain_b[0], si_b};
    end
    assign so_b = chain_b[1];

    // ---------------- 16-bit instance ----------------
    logic        sv_c = 1'b0, cap_c = 1'b0, dr_c = 1'b0;
    logic [15:0] sd_c = 16'h0000;
    logic        sr_c, ce_c, se_c, si_c, so_c, busy_c, dv_c;
    logic [15:0] dd_c;
    logic [1:0]  st_c;
    logic [15:0] chain_c = 16'h0000;
    logic [15:0] din_c   = 16'h0000;

    scan_chain_controller #(.CHAIN_LEN(16)) u_c (
        .clk(clk), .rst(rst),
        .start_valid(sv_c), .start_ready(sr_c), .start_data(sd_c), .start_capture(cap_c),
        .capture_enable(ce_c), .scan_enable(se_c), .scan_in(si_c), .scan_out(so_c),
        .busy(busy_c), .done_valid(dv_c), .done_ready(dr_c), .done_data(dd_c),
        .dbg_state(st_c)
    );

    always @(posedge clk) begin
        if (ce_c)      chain_c <= din_c;
        else if (se_c) chain_c <= {chain_c[14:0], si_c};
    end
    assign so_c = chain_c[15];

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8-bit transaction with cycle-exact checks. exp_old is the hand-computed
    // chain content expected back; hold is the number of DONE cycles with
    // done_ready low (start_valid is pulsed during them and must be ignored).
    task automatic run_a(input logic [7:0] data, input logic cap, input logic [7:0] exp_old,
                         input int hold);
        logic [15:0] exp_w;
        exp_q.push_back({8'h00, exp_old});
        check_eq("a_ready_before", {31'd0, sr_a}, 32'd1);
        sv_a = 1'b1; sd_a = data; cap_a = cap;
        tick();
        sv_a = 1'b0; sd_a = 8'h00; cap_a = 1'b0;
        check_eq("a_ready_low", {31'd0, sr_a}, 32'd0);
        check_eq("a_busy", {31'd0, busy_a}, 32'd1);
        if (cap) begin
            check_eq("a_cap_pulse", {30'd0, ce_a, se_a}, 32'b10);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("a_shift%0d_en", i), {30'd0, ce_a, se_a}, 32'b01);
            check_eq($sformatf("a_shift%0d_si", i), {31'd0, si_a}, {31'd0, data[7-i]});
            tick();
        end
        exp_w = exp_q.pop_front();
        check_eq("a_done_valid", {31'd0, dv_a}, 32'd1);
        check_eq("a_done_data", {24'd0, dd_a}, {16'd0, exp_w});
        check_eq("a_done_idle_outs", {28'd0, ce_a, se_a, si_a, busy_a}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            sv_a = h[0]; sd_a = 8'h99; cap_a = 1'b1;
            tick();
            check_eq($sformatf("a_hold%0d_dv", h), {31'd0, dv_a}, 32'd1);
            check_eq($sformatf("a_hold%0d_dd", h), {24'd0, dd_a}, {16'd0, exp_w});
            check_eq($sformatf("a_hold%0d_sr", h), {29'd0, sr_a, ce_a, se_a}, 32'd0);
        end
        sv_a = 1'b0; sd_a = 8'h00; cap_a = 1'b0;
        dr_a = 1'b1;
        tick();
        dr_a = 1'b0;
        check_eq("a_done_drop", {31'd0, dv_a}, 32'd0);
        check_eq("a_idle_ready", {30'd0, sr_a, busy_a}, 32'b10);
        check_eq("a_idle_state", {30'd0, st_a}, 32'd0);
        check_eq("a_chain", {24'd0, chain_a}, {24'd0, data});
    endtask

    task automatic run_b(input logic [1:0] data);
        logic [15:0] exp_w;
        int k;
        exp_q.push_back({14'd0, chain_b});
        sv_b = 1'b1; sd_b = data;
        tick();
        sv_b = 1'b0;
        k = 0;
        while (!dv_b && k < 40) begin tick(); k++; end
        check_eq("b_done_seen", {31'd0, dv_b}, 32'd1);
        exp_w = exp_q.pop_front();
        check_eq("b_done_data", {30'd0, dd_b}, {16'd0, exp_w});
        dr_b = 1'b1;
        tick();
        dr_b = 1'b0;
        check_eq("b_chain", {30'd0, chain_b}, {30'd0, data});
    endtask

    task automatic run_c(input logic [15:0] data, input logic cap, input logic [15:0] din);
        logic [15:0] exp_w;
        int k;
        din_c = din;
        exp_q.push_back(cap ? din : chain_c);
        sv_c = 1'b1; sd_c = data; cap_c = cap;
        tick();
        sv_c = 1'b0; cap_c = 1'b0;
        k = 0;
        while (!dv_c && k < 60) begin tick(); k++; end
        check_eq("c_done_seen", {31'd0, dv_c}, 32'd1);
        exp_w = exp_q.pop_front();
        check_eq("c_done_data", {16'd0, dd_c}, {16'd0, exp_w});
        dr_c = 1'b1;
        tick();
        dr_c = 1'b0;
        check_eq("c_chain", {16'd0, chain_c}, {16'd0, data});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        tick(); tick();
        check_eq("rst_outs", {25'd0, sr_a, ce_a, se_a, si_a, busy_a, dv_a, 1'b0}, 32'b1000000);
        check_eq("rst_done_data", {24'd0, dd_a}, 32'd0);
        check_eq("rst_state", {30'd0, st_a}, 32'd0);
        rst = 1'b1;
        tick();

        // Basic load, then back-to-back with backpressure.
        run_a(8'hA5, 1'b0, 8'h00, 0);
        run_a(8'h3C, 1'b0, 8'hA5, 5);

        // Capture mode: snapshot 0x5A, shift in 0xFF.
        din_a = 8'h5A;
        run_a(8'hFF, 1'b1, 8'h5A, 0);

        // Reset after three shift edges; the reset edge itself also shifts the
        // chain once more, leaving 0xFF<<4 | 0b0001 = 0xF1.
        sv_a = 1'b1; sd_a = 8'h11;
        tick();
        sv_a = 1'b0; sd_a = 8'h00;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("mid_rst_outs", {28'd0, se_a, busy_a, dv_a, sr_a}, 32'b0001);
        check_eq("mid_rst_chain", {24'd0, chain_a}, 32'hF1);
        run_a(8'hA5, 1'b0, 8'hF1, 0);

        // Width sweep.
        for (int i = 0; i < 4; i++) run_b(2'($urandom_range(0, 3)));
        for (int i = 0; i < 4; i++)
            run_c(16'($urandom_range(0, 65535)), i[0], 16'($urandom_range(0, 65535)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
